vga_timing_gen: RTL and testbench

//   Parametrised raster timing generator for the VGA display path (clk_vga pixel clock).

---
 rtl/vga_timing_gen.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters, a registered stage-0 decode for
// pixel coordinates and strobes, a PIPE-deep delay for sync/DE, frame counter and marquee scroll.
module vga_timing_gen #(
  parameter int H_SYNC     = 136,
  parameter int H_BACK     = 160,
  parameter int H_DISP     = 1024,
  parameter int H_FRONT    = 24,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 29,
  parameter int V_DISP     = 768,
  parameter int V_FRONT    = 3,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int PIPE       = 2,
  parameter int SCROLL_DIV = 1,
  parameter int SCROLL_MAX = 1024
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        timing_en,
  input  logic        scroll_en,
  input  logic        scroll_rst,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_de,
  output logic        vga_h_sync,
  output logic        vga_v_sync,
  output logic        vga_de,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic [10:0] scroll_off
);

  localparam int H_TOT = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_DISP + V_FRONT;

  generate
    if (H_TOT > 2048 || V_TOT > 2048) begin : g_bad_total
      $error("vga_timing_gen: H_TOT/V_TOT must be <= 2048");
    end
    if (PIPE < 0 || PIPE > 15) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE must be 0..15");
    end
    if (SCROLL_DIV < 1 || SCROLL_DIV > 65536) begin : g_bad_div
      $error("vga_timing_gen: SCROLL_DIV must be 1..65536");
    end
    if (SCROLL_MAX < 2 || SCROLL_MAX > 2048) begin : g_bad_max
      $error("vga_timing_gen: SCROLL_MAX must be 2..2048");
    end
  endgenerate

  // Counters are 12 bits so the active-area end (up to 2048) is representable.
  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [11:0] HS_END   = 12'(H_SYNC);
  localparam logic [11:0] VS_END   = 12'(V_SYNC);
  localparam logic [11:0] HA_BEG   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END   = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] VA_BEG   = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_END   = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [15:0] DIV_LAST = 16'(SCROLL_DIV - 1);
  localparam logic [10:0] OFF_LAST = 11'(SCROLL_MAX - 1);
  localparam logic        H_ACT    = 1'(H_POL);
  localparam logic        V_ACT    = 1'(V_POL);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        hs0;
  logic        vs0;
  logic [15:0] div_cnt;
  logic        h_act;
  logic        v_act;
  logic        frame_tick;

  assign h_act      = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
  assign v_act      = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
  assign frame_tick = timing_en && (h_cnt == '0) && (v_cnt == '0);

  // Disabling timing parks the raster at the origin, so re-enable restarts a frame.
  always_ff @(posedge clk_vga) begin
    if (!rst_n || !timing_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n || !timing_en) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_de      <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_de      <= h_act && v_act;
      pix_x       <= (h_act && v_act) ? 11'(h_cnt - HA_BEG) : '0;
      pix_y       <= (h_act && v_act) ? 11'(v_cnt - VA_BEG) : '0;
      hs0         <= h_cnt < HS_END;
      vs0         <= v_cnt < VS_END;
      line_start  <= h_cnt == '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Scroll only moves on the frame boundary so a frame never shows two offsets.
  always_ff @(posedge clk_vga) begin
    if (!rst_n || scroll_rst) begin
      div_cnt    <= '0;
      scroll_off <= '0;
    end else if (frame_tick && scroll_en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        scroll_off <= (scroll_off == '0) ? OFF_LAST : scroll_off - 11'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  logic hs_d;
  logic vs_d;
  logic de_d;

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign hs_d = hs0;
      assign vs_d = vs0;
      assign de_d = pix_de;
    end else begin : g_pipe
      logic [PIPE-1:0] hs_q;
      logic [PIPE-1:0] vs_q;
      logic [PIPE-1:0] de_q;

      always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
          hs_q <= '0;
          vs_q <= '0;
          de_q <= '0;
        end else begin
          hs_q[0] <= hs0;
          vs_q[0] <= vs0;
          de_q[0] <= pix_de;
          for (int i = 1; i < PIPE; i++) begin
            hs_q[i] <= hs_q[i-1];
            vs_q[i] <= vs_q[i-1];
            de_q[i] <= de_q[i-1];
          end
        end
      end

      assign hs_d = hs_q[PIPE-1];
      assign vs_d = vs_q[PIPE-1];
      assign de_d = de_q[PIPE-1];
    end
  endgenerate

  // Raw syncs are active-high internally; cleared stages therefore read as inactive.
  assign vga_h_sync = hs_d ? H_ACT : ~H_ACT;
  assign vga_v_sync = vs_d ? V_ACT : ~V_ACT;
  assign vga_de     = de_d;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two small-raster instances (PIPE=3 active-high hsync,
// PIPE=0 active-low) plus one default-parameter instance for full-size line/vsync timing.
module tb_vga_timing_gen;

  logic clk_vga = 1'b0;
  logic rst_n, timing_en, scroll_en, scroll_rst;
  int   cyc;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_vga = ~clk_vga;

  logic [10:0] pix_x_a, pix_y_a, scroll_a, pix_x_b, pix_y_b, scroll_b, pix_x_d, pix_y_d, scroll_d;
  logic        de_a, hs_a, vs_a, vde_a, ls_a, fs_a;
  logic        de_b, hs_b, vs_b, vde_b, ls_b, fs_b;
  logic        de_d, hs_d, vs_d, vde_d, ls_d, fs_d;
  logic [15:0] fc_a, fc_b, fc_d;

  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
                   .H_POL(1), .V_POL(0), .PIPE(3), .SCROLL_DIV(2), .SCROLL_MAX(16)) dut_a (
    .clk_vga(clk_vga), .rst_n(rst_n), .timing_en(timing_en), .scroll_en(scroll_en),
    .scroll_rst(scroll_rst), .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_de(de_a),
    .vga_h_sync(hs_a), .vga_v_sync(vs_a), .vga_de(vde_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a), .scroll_off(scroll_a));

  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
                   .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
                   .H_POL(0), .V_POL(0), .PIPE(0), .SCROLL_DIV(1), .SCROLL_MAX(1024)) dut_b (
    .clk_vga(clk_vga), .rst_n(rst_n), .timing_en(timing_en), .scroll_en(scroll_en),
    .scroll_rst(scroll_rst), .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_de(de_b),
    .vga_h_sync(hs_b), .vga_v_sync(vs_b), .vga_de(vde_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b), .scroll_off(scroll_b));

  vga_timing_gen dut_d (
    .clk_vga(clk_vga), .rst_n(rst_n), .timing_en(timing_en), .scroll_en(scroll_en),
    .scroll_rst(scroll_rst), .pix_x(pix_x_d), .pix_y(pix_y_d), .pix_de(de_d),
    .vga_h_sync(hs_d), .vga_v_sync(vs_d), .vga_de(vde_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_cnt(fc_d), .scroll_off(scroll_d));

  task automatic step();
    @(posedge clk_vga);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_de_a(input string name);
    int budget;
    budget = 0;
    while (de_a !== 1'b1 && budget < 200) begin
      step();
      budget++;
    end
    n_checks++;
    if (de_a !== 1'b1) $display("FAIL %s_wait_de: pix_de not seen within %0d cycles", name, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; timing_en = 1'b1; scroll_en = 1'b1; scroll_rst = 1'b0;
    repeat (4) step();
    n_checks++;
    if ({de_a, pix_x_a, pix_y_a, ls_a, fs_a, vde_a} !== 25'd0)
      $display("FAIL reset_pix_a: got de=%0b x=%0d y=%0d ls=%0b fs=%0b vde=%0b want all 0",
               de_a, pix_x_a, pix_y_a, ls_a, fs_a, vde_a);
    else n_pass++;
    n_checks++;
    if ({hs_a, vs_a, hs_b, vs_b} !== 4'b0111)
      $display("FAIL reset_syncs: got hs_a=%0b vs_a=%0b hs_b=%0b vs_b=%0b want 0 1 1 1", hs_a, vs_a, hs_b, vs_b);
    else n_pass++;
    n_checks++;
    if (fc_a !== 16'd0 || scroll_a !== 11'd0 || scroll_b !== 11'd0)
      $display("FAIL reset_counters: got fc=%0d scroll_a=%0d scroll_b=%0d want 0 0 0", fc_a, scroll_a, scroll_b);
    else n_pass++;
  endtask

  // Frame 1 after release: cycle k shows stage-0 decode of raster position k-1.
  task automatic test_raster();
    int de_cnt, ls_cnt, fs_cnt, bad_idle, first_de, last_de;
    logic [10:0] fx, fy, lx, ly;
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; bad_idle = 0; first_de = 0; last_de = 0;
    fx = '1; fy = '1; lx = '1; ly = '1;
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 98; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (fs_a !== 1'b1 || ls_a !== 1'b1 || fc_a !== 16'd1)
          $display("FAIL first_frame_start: got fs=%0b ls=%0b fc=%0d want 1 1 1", fs_a, ls_a, fc_a);
        else n_pass++;
        n_checks++;
        if (scroll_a !== 11'd0 || scroll_b !== 11'd1023)
          $display("FAIL scroll_frame1: got a=%0d b=%0d want 0 1023", scroll_a, scroll_b);
        else n_pass++;
      end
      if (de_a) begin
        de_cnt++;
        if (first_de == 0) begin first_de = k; fx = pix_x_a; fy = pix_y_a; end
        last_de = k; lx = pix_x_a; ly = pix_y_a;
      end else if (pix_x_a != 0 || pix_y_a != 0) bad_idle++;
      if (ls_a) ls_cnt++;
      if (fs_a) fs_cnt++;
    end
    n_checks++;
    if (de_cnt != 32 || ls_cnt != 7 || fs_cnt != 1)
      $display("FAIL raster_counts: got de=%0d ls=%0d fs=%0d want 32 7 1", de_cnt, ls_cnt, fs_cnt);
    else n_pass++;
    n_checks++;
    if (first_de != 33 || fx !== 11'd0 || fy !== 11'd0)
      $display("FAIL first_pixel: got cyc=%0d x=%0d y=%0d want 33 0 0", first_de, fx, fy);
    else n_pass++;
    n_checks++;
    if (last_de != 82 || lx !== 11'd7 || ly !== 11'd3)
      $display("FAIL last_pixel: got cyc=%0d x=%0d y=%0d want 82 7 3", last_de, lx, ly);
    else n_pass++;
    n_checks++;
    if (bad_idle != 0) $display("FAIL idle_coords: got %0d nonzero idle cycles want 0", bad_idle);
    else n_pass++;
  endtask

  // Frame 2, position j = cycle - 98.
  task automatic test_pipe();
    int de_j, vde_j, hs_a_j, vs_a_j, hs_a_n, vs_a_n, hs_b_j, hs_b_n, vs_b_n, de_b_mis;
    de_j = 0; vde_j = 0; hs_a_j = 0; vs_a_j = 0; hs_a_n = 0; vs_a_n = 0;
    hs_b_j = 0; hs_b_n = 0; vs_b_n = 0; de_b_mis = 0;
    for (int j = 1; j <= 98; j++) begin
      step();
      if (j == 1) begin
        n_checks++;
        if (fs_a !== 1'b1 || fc_a !== 16'd2)
          $display("FAIL frame_period: got fs=%0b fc=%0d at cycle 99 want 1 2", fs_a, fc_a);
        else n_pass++;
        n_checks++;
        if (scroll_a !== 11'd15 || scroll_b !== 11'd1022)
          $display("FAIL scroll_frame2: got a=%0d b=%0d want 15 1022", scroll_a, scroll_b);
        else n_pass++;
      end
      if (de_a && de_j == 0) de_j = j;
      if (vde_a && vde_j == 0) vde_j = j;
      if (hs_a) begin hs_a_n++; if (hs_a_j == 0) hs_a_j = j; end
      if (!vs_a) begin vs_a_n++; if (vs_a_j == 0) vs_a_j = j; end
      if (!hs_b) begin hs_b_n++; if (hs_b_j == 0) hs_b_j = j; end
      if (!vs_b) vs_b_n++;
      if (vde_b !== de_b) de_b_mis++;
    end
    n_checks++;
    if (de_j != 33 || vde_j != 36)
      $display("FAIL pipe_de: got pix_de at %0d vga_de at %0d want 33 36", de_j, vde_j);
    else n_pass++;
    n_checks++;
    if (hs_a_j != 4 || hs_a_n != 14)
      $display("FAIL pipe_hsync_a: got first=%0d count=%0d want 4 14", hs_a_j, hs_a_n);
    else n_pass++;
    n_checks++;
    if (vs_a_j != 4 || vs_a_n != 14)
      $display("FAIL pipe_vsync_a: got first=%0d count=%0d want 4 14", vs_a_j, vs_a_n);
    else n_pass++;
    n_checks++;
    if (hs_b_j != 1 || hs_b_n != 14 || vs_b_n != 14 || de_b_mis != 0)
      $display("FAIL nopipe_b: got hs_first=%0d hs_n=%0d vs_n=%0d de_mis=%0d want 1 14 14 0",
               hs_b_j, hs_b_n, vs_b_n, de_b_mis);
    else n_pass++;
  endtask

  task automatic test_scroll();
    run_to(197);
    n_checks++;
    if (scroll_a !== 11'd15 || scroll_b !== 11'd1021)
      $display("FAIL scroll_frame3: got a=%0d b=%0d want 15 1021", scroll_a, scroll_b);
    else n_pass++;
    run_to(250);
    n_checks++;
    if (scroll_a !== 11'd15) $display("FAIL scroll_midframe: got %0d want 15", scroll_a);
    else n_pass++;
    run_to(295);
    n_checks++;
    if (scroll_a !== 11'd14 || scroll_b !== 11'd1020 || fc_a !== 16'd4)
      $display("FAIL scroll_frame4: got a=%0d b=%0d fc=%0d want 14 1020 4", scroll_a, scroll_b, fc_a);
    else n_pass++;
    run_to(490);
    scroll_rst = 1'b1;
    step();
    scroll_rst = 1'b0;
    n_checks++;
    if (scroll_a !== 11'd0 || scroll_b !== 11'd0)
      $display("FAIL scroll_rst_step: got a=%0d b=%0d want 0 0", scroll_a, scroll_b);
    else n_pass++;
    scroll_en = 1'b0;
    run_to(589);
    n_checks++;
    if (scroll_a !== 11'd0 || scroll_b !== 11'd0 || fc_a !== 16'd7)
      $display("FAIL scroll_hold: got a=%0d b=%0d fc=%0d want 0 0 7", scroll_a, scroll_b, fc_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid_line();
    wait_de_a("midreset");
    step(); step();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (de_a !== 1'b0 || pix_x_a !== 11'd0 || vde_a !== 1'b0 || ls_a !== 1'b0)
      $display("FAIL midreset_pix: got de=%0b x=%0d vde=%0b ls=%0b want 0 0 0 0", de_a, pix_x_a, vde_a, ls_a);
    else n_pass++;
    n_checks++;
    if ({hs_a, vs_a, hs_b, fc_a} !== {3'b011, 16'd0})
      $display("FAIL midreset_sync: got hs_a=%0b vs_a=%0b hs_b=%0b fc=%0d want 0 1 1 0", hs_a, vs_a, hs_b, fc_a);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (fs_a !== 1'b1 || ls_a !== 1'b1 || fc_a !== 16'd1)
      $display("FAIL midreset_release: got fs=%0b ls=%0b fc=%0d want 1 1 1", fs_a, ls_a, fc_a);
    else n_pass++;
    step();
    n_checks++;
    if (fs_a !== 1'b0) $display("FAIL frame_start_width: got %0b want 0", fs_a);
    else n_pass++;
  endtask

  task automatic test_timing_en();
    int strobes;
    strobes = 0;
    wait_de_a("tim_en");
    repeat (3) step();
    timing_en = 1'b0;
    for (int s = 1; s <= 100; s++) begin
      step();
      if (fs_a || ls_a || de_a || pix_x_a != 0) strobes++;
      if (s == 1) begin
        n_checks++;
        if (hs_b !== 1'b1 || vde_b !== 1'b0)
          $display("FAIL tim_en_nopipe: got hs_b=%0b vde_b=%0b want 1 0", hs_b, vde_b);
        else n_pass++;
      end
      if (s == 3) begin
        n_checks++;
        if (vde_a !== 1'b1) $display("FAIL tim_en_pipe_tail: got vde=%0b want 1", vde_a);
        else n_pass++;
      end
      if (s == 4) begin
        n_checks++;
        if (vde_a !== 1'b0 || hs_a !== 1'b0 || vs_a !== 1'b1)
          $display("FAIL tim_en_idle: got vde=%0b hs=%0b vs=%0b want 0 0 1", vde_a, hs_a, vs_a);
        else n_pass++;
      end
    end
    n_checks++;
    if (strobes != 0 || fc_a !== 16'd1)
      $display("FAIL tim_en_hold: got active_cycles=%0d fc=%0d want 0 1", strobes, fc_a);
    else n_pass++;
    timing_en = 1'b1;
    step();
    n_checks++;
    if (fs_a !== 1'b1 || ls_a !== 1'b1 || fc_a !== 16'd2)
      $display("FAIL tim_en_restart: got fs=%0b ls=%0b fc=%0d want 1 1 2", fs_a, ls_a, fc_a);
    else n_pass++;
  endtask

  // Full-size default raster (PIPE=2): hsync low cycles 3..138, vsync low 3..8066.
  task automatic test_default_timing();
    int fall1, fall2, hs_low, vs_low;
    logic prev_hs;
    fall1 = 0; fall2 = 0; hs_low = 0; vs_low = 0;
    rst_n = 1'b0;
    repeat (2) step();
    prev_hs = hs_d;
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 8070; k++) begin
      step();
      if (prev_hs && !hs_d) begin
        if (fall1 == 0) fall1 = k;
        else if (fall2 == 0) fall2 = k;
      end
      prev_hs = hs_d;
      if (k <= 1344 && !hs_d) hs_low++;
      if (!vs_d) vs_low++;
    end
    n_checks++;
    if (fall1 != 3 || fall2 - fall1 != 1344)
      $display("FAIL hsync_period: got first=%0d period=%0d want 3 1344", fall1, fall2 - fall1);
    else n_pass++;
    n_checks++;
    if (hs_low != 136) $display("FAIL hsync_width: got %0d want 136", hs_low);
    else n_pass++;
    n_checks++;
    if (vs_low != 8064 || fc_d !== 16'd1)
      $display("FAIL vsync_width: got %0d fc=%0d want 8064 1", vs_low, fc_d);
    else n_pass++;
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_raster();
    test_pipe();
    test_scroll();
    test_reset_mid_line();
    test_timing_en();
    test_default_timing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
